// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared UDP header widths, default ports, state type and helpers
package udp_pkg;

  localparam int UDP_PORT_W     = 16;
  localparam int UDP_LEN_W      = 16;
  localparam int UDP_CRC_W      = 16;
  localparam int UDP_HEAD_BYTES = 8;

  localparam logic [15:0] UDP_DEF_PORT = 16'd18170;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    DATA = 2'd2
  } udp_state_e;

  // Number of set bits in a byte-enable vector of up to 8 lanes
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/udp_head_tx.sv
// rtl/udp_head_tx.sv - builds the 8-byte UDP header word from ports, length and checksum
module udp_head_tx import udp_pkg::*; #(
  parameter int                PORT_W   = UDP_PORT_W,
  parameter int                LEN_W    = UDP_LEN_W,
  parameter int                CRC_W    = UDP_CRC_W,
  parameter logic [PORT_W-1:0] DST_PORT = UDP_DEF_PORT,
  parameter logic [PORT_W-1:0] SRC_PORT = UDP_DEF_PORT,
  parameter int                HEAD_W   = 2*PORT_W + LEN_W + CRC_W
) (
  input  logic [LEN_W-1:0]  len_i,
  input  logic [CRC_W-1:0]  crc_i,
  output logic [HEAD_W-1:0] head_o
);

  // Source port sits in the low bits so it leaves first on the wire,
  // followed by destination port, length and checksum.
  assign head_o = {crc_i, len_i, DST_PORT, SRC_PORT};

endmodule

// File: rtl/udp_tx.sv
// rtl/udp_tx.sv - UDP transmit framer inserting the header ahead of a payload stream
module udp_tx import udp_pkg::*; #(
  parameter int                DATA_W   = 16,
  parameter int                KEEP_W   = DATA_W / 8,
  parameter int                PORT_W   = UDP_PORT_W,
  parameter logic [PORT_W-1:0] DST_PORT = UDP_DEF_PORT,
  parameter logic [PORT_W-1:0] SRC_PORT = UDP_DEF_PORT,
  parameter int                LEN_W    = UDP_LEN_W,
  parameter int                CRC_W    = UDP_CRC_W,
  parameter bit                HAS_CRC  = 1'b0,
  parameter int                HEAD_W   = 2*PORT_W + LEN_W + CRC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic [KEEP_W-1:0] s_keep_i,
  input  logic              s_last_i,
  input  logic [LEN_W-1:0]  s_len_i,
  input  logic [CRC_W-1:0]  s_crc_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [KEEP_W-1:0] m_keep_o,
  output logic              m_last_o,
  output logic              len_err_o
);

  localparam int N_HB = HEAD_W / DATA_W;
  localparam int HB_W = (N_HB > 1) ? $clog2(N_HB) : 1;

  localparam logic [HB_W-1:0]  HB_LAST = HB_W'(N_HB - 1);
  localparam logic [LEN_W-1:0] LEN_ADD = LEN_W'(UDP_HEAD_BYTES);
  // Largest payload length whose UDP length still fits the field.
  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}} - LEN_ADD;

  udp_state_e        state_q, state_d;
  logic [HB_W-1:0]   hb_cnt_q, hb_cnt_d;
  logic [LEN_W-1:0]  udp_len_q, udp_len_d;
  logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic              len_err_q, len_err_d;

  logic [HEAD_W-1:0] head_word;
  logic [DATA_W-1:0] head_beat;
  logic [3:0]        beat_bytes;
  logic [LEN_W:0]    cnt_sum_wide;
  logic [LEN_W-1:0]  cnt_sum;
  logic              s_fire;

  udp_head_tx #(
    .PORT_W   (PORT_W),
    .LEN_W    (LEN_W),
    .CRC_W    (CRC_W),
    .DST_PORT (DST_PORT),
    .SRC_PORT (SRC_PORT),
    .HEAD_W   (HEAD_W)
  ) u_head (
    .len_i  (udp_len_q),
    .crc_i  (crc_q),
    .head_o (head_word)
  );

  // Pick the header slice for the current header beat; beat k is head[k*DATA_W +: DATA_W]
  always_comb begin
    head_beat = '0;
    for (int k = 0; k < N_HB; k++) begin
      if (hb_cnt_q == HB_W'(k)) begin
        head_beat = head_word[k*DATA_W +: DATA_W];
      end
    end
  end

  // Payload byte count including the beat being accepted, saturating at all ones
  always_comb begin
    beat_bytes   = popcount8(8'(s_keep_i));
    cnt_sum_wide = {1'b0, byte_cnt_q} + (LEN_W+1)'(beat_bytes);
    cnt_sum      = cnt_sum_wide[LEN_W] ? {LEN_W{1'b1}} : cnt_sum_wide[LEN_W-1:0];
  end

  assign s_fire    = s_valid_i & m_ready_i;
  assign len_err_o = len_err_q;

  // State and frame bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hb_cnt_q   <= '0;
      udp_len_q  <= '0;
      byte_cnt_q <= '0;
      crc_q      <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hb_cnt_q   <= hb_cnt_d;
      udp_len_q  <= udp_len_d;
      byte_cnt_q <= byte_cnt_d;
      crc_q      <= crc_d;
      len_err_q  <= len_err_d;
    end
  end

  // Next-state and stream steering: header beats from the generator, then payload pass-through
  always_comb begin
    state_d    = state_q;
    hb_cnt_d   = hb_cnt_q;
    udp_len_d  = udp_len_q;
    byte_cnt_d = byte_cnt_q;
    crc_d      = crc_q;
    len_err_d  = 1'b0;
    s_ready_o  = 1'b0;
    m_valid_o  = 1'b0;
    m_data_o   = '0;
    m_keep_o   = '0;
    m_last_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The first payload beat stays presented; only its side-band is captured here.
        if (s_valid_i) begin
          udp_len_d  = s_len_i + LEN_ADD;
          crc_d      = HAS_CRC ? s_crc_i : '0;
          hb_cnt_d   = '0;
          byte_cnt_d = '0;
          len_err_d  = (s_len_i == '0) || (s_len_i > LEN_MAX);
          state_d    = HEAD;
        end
      end

      HEAD: begin
        m_valid_o = 1'b1;
        m_data_o  = head_beat;
        m_keep_o  = {KEEP_W{1'b1}};
        if (m_ready_i) begin
          if (hb_cnt_q == HB_LAST) begin
            state_d = DATA;
          end else begin
            hb_cnt_d = hb_cnt_q + HB_W'(1);
          end
        end
      end

      DATA: begin
        m_valid_o = s_valid_i;
        s_ready_o = m_ready_i;
        m_data_o  = s_data_i;
        m_keep_o  = s_keep_i;
        m_last_o  = s_last_i;
        if (s_fire) begin
          byte_cnt_d = cnt_sum;
          if (s_last_i) begin
            // Compare in the length-field domain so only the wide register is kept.
            len_err_d = ((cnt_sum + LEN_ADD) != udp_len_q);
            state_d   = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
